// File: rtl/rom_arb_pkg.sv
// ============================================================================
// Module  : rom_arb_pkg
// Brief   : Shared constants for the monitor-ROM arbiter (port IDs, owner codes).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

    // Which port, if any, owns the data the ROM presents next cycle
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_M0   = 2'd1;
    localparam logic [1:0] OWN_M1   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rom_arb_wait_ctr.sv
// ============================================================================
// Module  : rom_arb_wait_ctr
// Brief   : Saturating count of consecutive cycles port 1 was denied; raises
//           o_force once the count reaches MAX_WAIT.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arb_wait_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_force
);

    localparam logic [3:0] c_MAX = 4'(MAX_WAIT);

    logic [3:0] r_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 4'd0;
        end else if (!i_req || i_gnt) begin
            r_wait <= 4'd0;
        end else if (r_wait != c_MAX) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    assign o_force = (r_wait == c_MAX);

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module  : rom_arbiter
// Brief   : Two-port arbiter in front of the synchronous-read monitor ROM.
//           Port 0 has fixed priority with a port-1 starvation guard; define
//           ROM_ARB_ROUND_ROBIN_EN to use round robin instead.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_pref1;
    logic [1:0]        r_owner;
    logic [ADDR_W-1:0] r_last_addr;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic r_last_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_win <= PORT_M1;
        end else if (w_gnt0) begin
            r_last_win <= PORT_M0;
        end else if (w_gnt1) begin
            r_last_win <= PORT_M1;
        end
    end

    assign w_pref1 = (r_last_win == PORT_M0);
`else
    rom_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_req   (m1_req),
        .i_gnt   (w_gnt1),
        .o_force (w_pref1)
    );
`endif

    always_comb begin
        w_gnt1 = !rst && m1_req && (!m0_req || w_pref1);
        w_gnt0 = !rst && m0_req && !w_gnt1;
    end

    // Idle cycles replay the last granted address so the ROM never sees X
    always_comb begin
        rom_addr = r_last_addr;
        if (w_gnt1) begin
            rom_addr = m1_addr;
        end else if (w_gnt0) begin
            rom_addr = m0_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_NONE;
            r_last_addr <= '0;
        end else begin
            if (w_gnt0) begin
                r_owner <= OWN_M0;
            end else if (w_gnt1) begin
                r_owner <= OWN_M1;
            end else begin
                r_owner <= OWN_NONE;
            end
            if (w_gnt0 || w_gnt1) begin
                r_last_addr <= rom_addr;
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = !rst && (r_owner == OWN_M0);
    assign m1_rvalid = !rst && (r_owner == OWN_M1);
    assign m0_rdata  = rom_dout;
    assign m1_rdata  = rom_dout;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module  : tb_rom_arbiter
// Brief   : Self-checking bench for rom_arbiter with a ROM image and a
//           cycle-level reference model (honours ROM_ARB_ROUND_ROBIN_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic              m0_gnt, m1_gnt;
    logic              m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;

    logic [7:0] rom_img [256];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_own;
    logic [7:0] m_own_addr;
    logic [7:0] m_last_addr;
    int         m_wait;
    int         m_lastwin;
    bit         m_g0, m_g1;
    int         m1_grants;

    rom_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom_img[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model
    task automatic step(input logic r, input logic q0, input logic [7:0] a0,
                        input logic q1, input logic [7:0] a1);
        bit         e0, e1, pref1;
        logic [7:0] ea;
        rst = r; m0_req = q0; m0_addr = a0; m1_req = q1; m1_addr = a1;
        #1;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        pref1 = (m_lastwin == 0);
`else
        pref1 = (m_wait == MAX_WAIT);
`endif
        e1 = !r && q1 && (!q0 || pref1);
        e0 = !r && q0 && !e1;
        ea = e1 ? a1 : (e0 ? a0 : m_last_addr);
        chk("m0_gnt", 32'(m0_gnt), 32'(e0));
        chk("m1_gnt", 32'(m1_gnt), 32'(e1));
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(!r && m_own == 1));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(!r && m_own == 2));
        if (!r && m_own == 1) chk("m0_rdata", 32'(m0_rdata), 32'(rom_img[m_own_addr]));
        if (!r && m_own == 2) chk("m1_rdata", 32'(m1_rdata), 32'(rom_img[m_own_addr]));
        m_g0 = e0;
        m_g1 = e1;
        if (e1) m1_grants++;
        @(posedge clk);
        m_own      = r ? 0 : (e0 ? 1 : (e1 ? 2 : 0));
        m_own_addr = ea;
        if (r) m_last_addr = 8'h00;
        else if (e0 || e1) m_last_addr = ea;
        if (r || !q1 || e1) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        if (r) m_lastwin = 1;
        else if (e0) m_lastwin = 0;
        else if (e1) m_lastwin = 1;
        #1;
    endtask

    initial begin
        logic       q0, q1, rr;
        logic [7:0] a0, a1;
        for (int i = 0; i < 256; i++) rom_img[i] = 8'(i * 37 + 11);
        rom_img[8'h00] = 8'hD8;
        rom_img[8'hFC] = 8'h00;
        rom_img[8'hFD] = 8'hFF;
        m_own = 0; m_own_addr = 8'h00; m_last_addr = 8'h00;
        m_wait = 0; m_lastwin = 1; m1_grants = 0;

        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_addr = 8'h00; m1_addr = 8'h00;
        @(posedge clk); #1;

        // Reset: requests must be ignored
        step(1, 1, 8'h10, 1, 8'h20);
        step(1, 0, 8'h00, 0, 8'h00);

        // Port 0 alone at 0x00
        step(0, 1, 8'h00, 0, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00);
        chk("m0_rdata_D8", 32'(m0_rdata), 32'hD8);

        // Port 1 back-to-back 0xFC, 0xFD, then idle
        step(0, 0, 8'h00, 1, 8'hFC);
        step(0, 0, 8'h00, 1, 8'hFD);
        step(0, 0, 8'h00, 0, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00);
        chk("idle_rom_addr", 32'(rom_addr), 32'hFD);
        step(0, 0, 8'h00, 0, 8'h00);

        // Continuous contention
        m1_grants = 0;
        for (int i = 0; i < 20; i++) step(0, 1, 8'h00, 1, 8'hFD);
`ifdef ROM_ARB_ROUND_ROBIN_EN
        chk("contention_m1_grants", 32'(m1_grants), 32'd10);
`else
        chk("contention_m1_grants", 32'(m1_grants), 32'd4);
`endif
        step(0, 0, 8'h00, 0, 8'h00);

        // Reset right after a grant kills the pending read
        step(0, 1, 8'h00, 0, 8'h00);
        step(1, 1, 8'h00, 1, 8'h40);
        step(1, 0, 8'h00, 0, 8'h00);
        step(0, 1, 8'h00, 0, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00);

        // Randomised traffic with held requests, withdrawals and rare resets
        q0 = 1'b0; q1 = 1'b0; a0 = 8'h00; a1 = 8'h00;
        for (int i = 0; i < 500; i++) begin
            if (!q0 || m_g0) begin
                q0 = ($urandom_range(0, 3) != 0);
                a0 = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                q0 = 1'b0;
            end
            if (!q1 || m_g1) begin
                q1 = ($urandom_range(0, 2) != 0);
                a1 = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                q1 = 1'b0;
            end
            rr = ($urandom_range(0, 63) == 0);
            step(rr, q0, a0, q1, a1);
        end
        step(0, 0, 8'h00, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
